instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the combinational 64x32 instruction memory. Owns the program counter
//  and drives the memory address. Registers each fetched word into a one-entry output stage

---
 rtl/instr_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a combinational instruction memory: owns the PC, registers fetched
// words into a one-entry valid/ready stage, and stops on an all-zero word. Optional perf counters: FETCH_PERF_EN.
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               busy,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_stall,
`endif
    output logic               done
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam int unsigned       PERF_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 if_valid_d;
    logic [INSTR_W-1:0]   if_instr_d;
    logic [ADDR_W-1:0]    if_pc_d;
    logic                 busy_d, done_d;
    logic                 start_acc;
    logic                 handshake;
    logic                 slot_free;
    logic                 word_zero;

    assign handshake = if_valid & id_ready;
    assign slot_free = ~if_valid | id_ready;
    assign word_zero = (imem_data == '0);
    assign imem_addr = pc_q;

    // Next-state, PC and output-stage update; redirect outranks everything while active
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid;
        if_instr_d = if_instr;
        if_pc_d    = if_pc;
        start_acc  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = RESET_PC_A;
                    start_acc = 1'b1;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redirect_pc;
                end else if (slot_free) begin
                    if (!word_zero) begin
                        if_instr_d = imem_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                    end else begin
                        // end of program: the slot is either empty or being accepted now
                        if_valid_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redirect_pc;
                    state_d    = S_FETCH;
                end else if (!if_valid) begin
                    state_d = S_DONE;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC_A;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_valid <= if_valid_d;
            if_instr <= if_instr_d;
            if_pc    <= if_pc_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

`ifdef FETCH_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Saturating handshake and stall counters, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else if (start_acc) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (handshake && (perf_fetch != PERF_MAX)) begin
                perf_fetch <= perf_fetch + PERF_W'(1);
            end
            if (if_valid && !id_ready && (perf_stall != PERF_MAX)) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = &{1'b0, start_acc, handshake, PERF_W[0]};
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed per-cycle vector table, reset/ignore sequences,
// and randomized programs checked against a delivered-stream scoreboard.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_pc = '0;
    logic        busy;
    logic        done;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch;
    logic [15:0] perf_stall;
`endif

    logic [31:0] mem [64];
    assign imem_data = mem[imem_addr];

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
`ifdef FETCH_PERF_EN
        .perf_fetch     (perf_fetch),
        .perf_stall     (perf_stall),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s, r, d;
        logic [5:0]  rp;
        logic        ev;
        logic [5:0]  epc;
        logic [31:0] ei;
        logic        eb, ed;
        logic [5:0]  ea;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic d, input logic [5:0] rp,
                                input logic ev, input logic [5:0] epc, input logic [31:0] ei,
                                input logic eb, input logic ed, input logic [5:0] ea);
        vec_t v;
        v.s = s; v.r = r; v.d = d; v.rp = rp; v.ev = ev; v.epc = epc; v.ei = ei;
        v.eb = eb; v.ed = ed; v.ea = ea;
        return v;
    endfunction

    localparam logic [31:0] W0 = 32'h0020_0003;
    localparam logic [31:0] W1 = 32'h0040_0002;
    localparam logic [31:0] W2 = 32'h1064_0022;
    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  exp_pc;
        logic [31:0] w;
        int          n_redir, n_fetch, n_stall;
        bit          finished;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[6'h3E] = WA; mem[6'h3F] = WB;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_valid", {31'b0, if_valid}, 32'd0);
        chk("reset if_instr", if_instr, 32'd0);
        chk("reset if_pc", {26'b0, if_pc}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset imem_addr", {26'b0, imem_addr}, 32'd0);
        rst_n = 1'b1;

        //          s  r  d  rp     ev epc    ei  eb ed ea
        tbl.push_back(mk(1, 1, 0, 6'h00, 0, 6'h00, 0,  1, 0, 6'h00));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h00, W0, 1, 0, 6'h01));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 0, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 0, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 0, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h02, W2, 1, 0, 6'h03));
        tbl.push_back(mk(0, 1, 0, 6'h00, 0, 6'h00, 0,  1, 0, 6'h03));
        tbl.push_back(mk(0, 1, 0, 6'h00, 0, 6'h00, 0,  0, 1, 6'h03));
        tbl.push_back(mk(0, 1, 0, 6'h00, 0, 6'h00, 0,  0, 1, 6'h03));
        tbl.push_back(mk(1, 1, 0, 6'h00, 0, 6'h00, 0,  1, 0, 6'h00));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h00, W0, 1, 0, 6'h01));
        tbl.push_back(mk(1, 1, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 0, 1, 6'h3E, 0, 6'h00, 0,  1, 0, 6'h3E));
        tbl.push_back(mk(0, 0, 0, 6'h00, 1, 6'h3E, WA, 1, 0, 6'h3F));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h3F, WB, 1, 0, 6'h00));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h00, W0, 1, 0, 6'h01));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h01, W1, 1, 0, 6'h02));
        tbl.push_back(mk(0, 1, 0, 6'h00, 1, 6'h02, W2, 1, 0, 6'h03));
        tbl.push_back(mk(0, 1, 0, 6'h00, 0, 6'h00, 0,  1, 0, 6'h03));
        tbl.push_back(mk(0, 1, 0, 6'h00, 0, 6'h00, 0,  0, 1, 6'h03));
        tbl.push_back(mk(0, 1, 1, 6'h05, 0, 6'h00, 0,  0, 1, 6'h03));

        foreach (tbl[i]) begin
            start = tbl[i].s; id_ready = tbl[i].r;
            redirect_valid = tbl[i].d; redirect_pc = tbl[i].rp;
            step();
            chk($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
            chk($sformatf("row%0d done", i), {31'b0, done}, {31'b0, tbl[i].ed});
            chk($sformatf("row%0d imem_addr", i), {26'b0, imem_addr}, {26'b0, tbl[i].ea});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d if_pc", i), {26'b0, if_pc}, {26'b0, tbl[i].epc});
                chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].ei);
            end
`ifdef FETCH_PERF_EN
            if (i == 9) begin
                chk("perf_fetch after stall run", {16'b0, perf_fetch}, 32'd3);
                chk("perf_stall after stall run", {16'b0, perf_stall}, 32'd3);
            end
            if (i == 10) begin
                chk("perf_fetch cleared by start", {16'b0, perf_fetch}, 32'd0);
                chk("perf_stall cleared by start", {16'b0, perf_stall}, 32'd0);
            end
`endif
        end
        start = 1'b0; redirect_valid = 1'b0;

        // async reset mid-FETCH, then redirect in IDLE ignored, then restart from 0
        start = 1'b1; id_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("pre-reset if_valid", {31'b0, if_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst if_valid", {31'b0, if_valid}, 32'd0);
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst imem_addr", {26'b0, imem_addr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 6'h09;
        step();
        redirect_valid = 1'b0;
        chk("idle redirect busy", {31'b0, busy}, 32'd0);
        chk("idle redirect imem_addr", {26'b0, imem_addr}, 32'd0);
        start = 1'b1; id_ready = 1'b1;
        step();
        start = 1'b0;
        chk("restart imem_addr", {26'b0, imem_addr}, 32'd0);
        step();
        chk("restart if_valid", {31'b0, if_valid}, 32'd1);
        chk("restart if_pc", {26'b0, if_pc}, 32'd0);
        chk("restart if_instr", if_instr, W0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // random programs: every delivered word must be the next word of the program stream
        for (int ep = 0; ep < 25; ep++) begin
            for (int i = 0; i < 64; i++) begin
                w = $urandom;
                if (w == 0) w = 32'd1;
                if ($urandom_range(15) == 0) w = 32'd0;
                mem[i] = w;
            end
            mem[$urandom_range(63)] = 32'd0;
            exp_pc = 6'd0; n_redir = 0; n_fetch = 0; n_stall = 0; finished = 1'b0;
            start = 1'b1; id_ready = 1'b0;
            step();
            start = 1'b0;
            for (int c = 0; c < 2000 && !finished; c++) begin
                id_ready = ($urandom_range(3) != 0);
                redirect_valid = busy && (n_redir < 3) && ($urandom_range(15) == 0);
                redirect_pc = 6'($urandom);
                if (if_valid && id_ready) begin
                    chk($sformatf("ep%0d deliver pc", ep), {26'b0, if_pc}, {26'b0, exp_pc});
                    chk($sformatf("ep%0d deliver instr", ep), if_instr, mem[exp_pc]);
                    checks++;
                    if (if_instr == 32'd0) begin
                        failures++;
                        $display("FAIL ep%0d zero word delivered: got %h expected nonzero", ep, if_instr);
                    end
                    exp_pc = exp_pc + 6'd1;
                    n_fetch++;
                end
                if (if_valid && !id_ready) n_stall++;
                if (redirect_valid) begin
                    exp_pc = redirect_pc;
                    n_redir++;
                end
                step();
                redirect_valid = 1'b0;
                if (done) finished = 1'b1;
            end
            checks++;
            if (!finished) begin
                failures++;
                $display("FAIL ep%0d timeout: got done=%0d expected done=1", ep, done);
            end
            chk($sformatf("ep%0d stop addr", ep), {26'b0, imem_addr}, {26'b0, exp_pc});
            chk($sformatf("ep%0d stop word", ep), mem[imem_addr], 32'd0);
            chk($sformatf("ep%0d done if_valid", ep), {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
            chk($sformatf("ep%0d perf_fetch", ep), {16'b0, perf_fetch}, 32'(n_fetch));
            chk($sformatf("ep%0d perf_stall", ep), {16'b0, perf_stall}, 32'(n_stall));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
